// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between a CPU port (0)
// and a loader/debug DMA port (1). One access per cycle, round-robin between
// ports, optional per-port lock for atomic sequences, registered memory command,
// and a read-tag pipe that routes each read result back to its issuing port.
module mem_arbiter #(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             p0_req,
    input  logic             p0_wr,
    input  logic             p0_lock,
    input  logic [DEPTH-1:0] p0_address,
    input  logic [WIDTH-1:0] p0_wr_data,
    output logic             p0_gnt,
    output logic             p0_rd_valid,
    output logic [WIDTH-1:0] p0_rd_data,

    input  logic             p1_req,
    input  logic             p1_wr,
    input  logic             p1_lock,
    input  logic [DEPTH-1:0] p1_address,
    input  logic [WIDTH-1:0] p1_wr_data,
    output logic             p1_gnt,
    output logic             p1_rd_valid,
    output logic [WIDTH-1:0] p1_rd_data,

    output logic             mem_enable,
    output logic             mem_wr_enable,
    output logic [DEPTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_t;

    lock_t            lock_q;
    logic             last_q;      // port most recently granted
    logic             gnt0, gnt1;

    logic             mem_en_q,   mem_en_d;
    logic             mem_wen_q,  mem_wen_d;
    logic [DEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdat_q, mem_wdat_d;

    // Read tags kept one-hot per port ({valid,port} split into two valid
    // vectors) so each port's rd_valid comes straight off a flop.
    logic [READ_LATENCY:0] tag0_q, tag0_d;
    logic [READ_LATENCY:0] tag1_q, tag1_d;

    // Grant selection: lock owner only, else single requester, else the port
    // that was not granted last. Reset forces both grants low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (lock_q)
            LOCKED0: gnt0 = p0_req;
            LOCKED1: gnt1 = p1_req;
            default: begin
                if (p0_req && p1_req) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
            end
        endcase
        if (!resetn) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    // Lock/round-robin FSM: only a granted edge moves ownership or the pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= UNLOCKED;
            last_q <= 1'b1;
        end else if (gnt0) begin
            lock_q <= p0_lock ? LOCKED0 : UNLOCKED;
            last_q <= 1'b0;
        end else if (gnt1) begin
            lock_q <= p1_lock ? LOCKED1 : UNLOCKED;
            last_q <= 1'b1;
        end
    end

    // Next memory command: winner's fields on a grant, otherwise idle with
    // address/data held so the memory pins do not toggle needlessly.
    always_comb begin
        mem_en_d   = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        if (gnt0) begin
            mem_en_d   = 1'b1;
            mem_wen_d  = p0_wr;
            mem_addr_d = p0_address;
            mem_wdat_d = p0_wr_data;
        end else if (gnt1) begin
            mem_en_d   = 1'b1;
            mem_wen_d  = p1_wr;
            mem_addr_d = p1_address;
            mem_wdat_d = p1_wr_data;
        end
    end

    // Registered memory command.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_en_q   <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
        end else begin
            mem_en_q   <= mem_en_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    assign mem_enable    = mem_en_q;
    assign mem_wr_enable = mem_wen_q;
    assign mem_address   = mem_addr_q;
    assign mem_wr_data   = mem_wdat_q;

    // Tag pipe shift: stage 0 is the command cycle, stage READ_LATENCY is the
    // cycle mem_rd_data is valid. Only granted reads enter a valid tag.
    always_comb begin
        tag0_d = {tag0_q[READ_LATENCY-1:0], gnt0 && !p0_wr};
        tag1_d = {tag1_q[READ_LATENCY-1:0], gnt1 && !p1_wr};
    end

    // Tag pipe registers; cleared on reset so in-flight reads are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag0_q <= '0;
            tag1_q <= '0;
        end else begin
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
        end
    end

    assign p0_rd_valid = tag0_q[READ_LATENCY];
    assign p1_rd_valid = tag1_q[READ_LATENCY];
    assign p0_rd_data  = mem_rd_data;
    assign p1_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency synchronous
// memory model. Memory is preloaded with mem[a] = a[7:0] + 4, so
// fffc=00, fffd=01, 0010=14, 0020=24, 8000=04.
module tb_mem_arbiter;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int RL    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             p0_req, p0_wr, p0_lock;
    logic [DEPTH-1:0] p0_address;
    logic [WIDTH-1:0] p0_wr_data;
    logic             p0_gnt, p0_rd_valid;
    logic [WIDTH-1:0] p0_rd_data;
    logic             p1_req, p1_wr, p1_lock;
    logic [DEPTH-1:0] p1_address;
    logic [WIDTH-1:0] p1_wr_data;
    logic             p1_gnt, p1_rd_valid;
    logic [WIDTH-1:0] p1_rd_data;
    logic             mem_enable, mem_wr_enable;
    logic [DEPTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wr_data;
    logic [WIDTH-1:0] mem_rd_data = '0;

    logic [WIDTH-1:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LATENCY(RL)) dut (
        .clk(clk), .resetn(resetn),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock),
        .p0_address(p0_address), .p0_wr_data(p0_wr_data),
        .p0_gnt(p0_gnt), .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_lock(p1_lock),
        .p1_address(p1_address), .p1_wr_data(p1_wr_data),
        .p1_gnt(p1_gnt), .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
        .mem_enable(mem_enable), .mem_wr_enable(mem_wr_enable),
        .mem_address(mem_address), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Single-port synchronous memory, read latency 1.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_wr_enable) mem[mem_address] = mem_wr_data;
            else               mem_rd_data <= mem[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_g0"},   32'(p0_gnt), 0);
        chk({tag, "_g1"},   32'(p1_gnt), 0);
        chk({tag, "_v0"},   32'(p0_rd_valid), 0);
        chk({tag, "_v1"},   32'(p1_rd_valid), 0);
        chk({tag, "_en"},   32'(mem_enable), 0);
        chk({tag, "_wen"},  32'(mem_wr_enable), 0);
        chk({tag, "_addr"}, 32'(mem_address), 0);
        chk({tag, "_wdat"}, 32'(mem_wr_data), 0);
    endtask

    // Move to the second half of the next cycle: inputs are changed right
    // after the falling edge, outputs are checked 1 time unit later.
    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i + 4);

        resetn = 1'b0;
        p0_req = 1'b1; p0_wr = 1'b0; p0_lock = 1'b0; p0_address = 16'h0010; p0_wr_data = 8'h00;
        p1_req = 1'b1; p1_wr = 1'b0; p1_lock = 1'b0; p1_address = 16'h0020; p1_wr_data = 8'h00;

        // Reset held 10 cycles with both ports requesting.
        for (int i = 0; i < 10; i++) begin
            mid(); #1;
            chk_reset("rst");
        end

        // Release reset; contention for 8 grants, then both drop.
        // Grants p0 at k=0,2,4,6 and p1 at k=1,3,5,7; reads return at k+2.
        for (int k = 0; k < 10; k++) begin
            mid();
            if (k == 0) resetn = 1'b1;
            if (k == 8) begin p0_req = 1'b0; p1_req = 1'b0; end
            #1;
            chk("cont_g0", 32'(p0_gnt), 32'(k < 8 && k % 2 == 0));
            chk("cont_g1", 32'(p1_gnt), 32'(k < 8 && k % 2 == 1));
            chk("cont_en", 32'(mem_enable), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8)
                chk("cont_addr", 32'(mem_address), (k % 2 == 1) ? 32'h0010 : 32'h0020);
            chk("cont_v0", 32'(p0_rd_valid), 32'(k >= 2 && k % 2 == 0));
            chk("cont_v1", 32'(p1_rd_valid), 32'(k >= 3 && k % 2 == 1));
            if (k >= 2 && k % 2 == 0) chk("cont_d0", 32'(p0_rd_data), 32'h14);
            if (k >= 3 && k % 2 == 1) chk("cont_d1", 32'(p1_rd_data), 32'h24);
        end

        // Single read of fffc by p0.
        mid(); p0_req = 1'b1; p0_wr = 1'b0; p0_address = 16'hfffc; #1;
        chk("rd_gnt", 32'(p0_gnt), 1);
        chk("rd_g1", 32'(p1_gnt), 0);
        mid(); p0_req = 1'b0; #1;
        chk("rd_en", 32'(mem_enable), 1);
        chk("rd_wen", 32'(mem_wr_enable), 0);
        chk("rd_addr", 32'(mem_address), 32'hfffc);
        chk("rd_v0_early", 32'(p0_rd_valid), 0);
        mid(); #1;
        chk("rd_v0", 32'(p0_rd_valid), 1);
        chk("rd_d0", 32'(p0_rd_data), 32'h00);
        chk("rd_v1", 32'(p1_rd_valid), 0);
        chk("rd_en_idle", 32'(mem_enable), 0);
        mid(); #1;
        chk("rd_v0_late", 32'(p0_rd_valid), 0);

        // p1 writes ff to 8000, then reads it back in the next cycle.
        mid(); p1_req = 1'b1; p1_wr = 1'b1; p1_address = 16'h8000; p1_wr_data = 8'hff; #1;
        chk("wr_gnt", 32'(p1_gnt), 1);
        mid(); p1_wr = 1'b0; #1;
        chk("wr_rgnt", 32'(p1_gnt), 1);
        chk("wr_en", 32'(mem_enable), 1);
        chk("wr_wen", 32'(mem_wr_enable), 1);
        chk("wr_addr", 32'(mem_address), 32'h8000);
        chk("wr_wdat", 32'(mem_wr_data), 32'hff);
        mid(); p1_req = 1'b0; #1;
        chk("wr_novalid", 32'(p1_rd_valid), 0);
        chk("wr_rd_wen", 32'(mem_wr_enable), 0);
        chk("wr_rd_en", 32'(mem_enable), 1);
        mid(); #1;
        chk("raw_v1", 32'(p1_rd_valid), 1);
        chk("raw_d1", 32'(p1_rd_data), 32'hff);
        chk("raw_v0", 32'(p0_rd_valid), 0);

        // Lock: p0 reads fffc locked, drops a cycle, reads fffd unlocked;
        // p1 requests throughout and must wait until after the fffd grant.
        mid();
        p0_req = 1'b1; p0_wr = 1'b0; p0_lock = 1'b1; p0_address = 16'hfffc;
        p1_req = 1'b1; p1_wr = 1'b0; p1_lock = 1'b0; p1_address = 16'h0020;
        #1;
        chk("lk0_g0", 32'(p0_gnt), 1);
        chk("lk0_g1", 32'(p1_gnt), 0);
        mid(); p0_req = 1'b0; #1;
        chk("lk1_g1_held", 32'(p1_gnt), 0);
        chk("lk1_g0", 32'(p0_gnt), 0);
        mid(); p0_req = 1'b1; p0_lock = 1'b0; p0_address = 16'hfffd; #1;
        chk("lk2_g0", 32'(p0_gnt), 1);
        chk("lk2_g1", 32'(p1_gnt), 0);
        chk("lk2_v0", 32'(p0_rd_valid), 1);
        chk("lk2_d0", 32'(p0_rd_data), 32'h00);
        mid(); p0_req = 1'b0; #1;
        chk("lk3_g1", 32'(p1_gnt), 1);
        chk("lk3_g0", 32'(p0_gnt), 0);
        chk("lk3_v0", 32'(p0_rd_valid), 0);
        mid(); p1_req = 1'b0; #1;
        chk("lk4_v0", 32'(p0_rd_valid), 1);
        chk("lk4_d0", 32'(p0_rd_data), 32'h01);
        chk("lk4_v1", 32'(p1_rd_valid), 0);
        mid(); #1;
        chk("lk5_v1", 32'(p1_rd_valid), 1);
        chk("lk5_d1", 32'(p1_rd_data), 32'h24);

        // Reset in the cycle after a locked p1 read grant.
        mid(); p1_req = 1'b1; p1_lock = 1'b1; p1_address = 16'h0020; #1;
        chk("mr_g1", 32'(p1_gnt), 1);
        mid(); p1_req = 1'b0; p1_lock = 1'b0; resetn = 1'b0; #1;
        chk_reset("mr_rst");
        mid(); resetn = 1'b1; #1;
        chk("mr_v1_a", 32'(p1_rd_valid), 0);
        mid(); #1;
        chk("mr_v1_b", 32'(p1_rd_valid), 0);
        chk("mr_v0_b", 32'(p0_rd_valid), 0);
        // Lock must be gone and last reset to 1: p0 wins contention.
        mid(); p0_req = 1'b1; p0_address = 16'h0010; p1_req = 1'b1; #1;
        chk("mr_g0", 32'(p0_gnt), 1);
        chk("mr_g1n", 32'(p1_gnt), 0);
        mid(); p0_req = 1'b0; #1;
        chk("mr_g1_next", 32'(p1_gnt), 1);
        mid(); p1_req = 1'b0; #1;
        chk("mr_v0_ret", 32'(p0_rd_valid), 1);
        chk("mr_d0_ret", 32'(p0_rd_data), 32'h14);
        mid(); #1;
        chk("mr_v1_ret", 32'(p1_rd_valid), 1);
        chk("mr_d1_ret", 32'(p1_rd_data), 32'h24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous `memory` block between two requesters: port 0 (CPU bus interface) and port 1 (loader/debug DMA).
- Accepts at most one access per cycle.
- Round-robin fairness between ports, plus a per-port lock for atomic multi-byte sequences such as the reset-vector fetch at fffc/fffd.
- Registers the memory command.
- Tracks the memory's read latency so each read returns a valid strobe to the port that issued it.

## Interface

- `DEPTH`, 16: address width in bits.
- `WIDTH`, 8: data width in bits.
- `READ_LATENCY`, 1: cycles from a command on the memory pins to valid `mem_rd_data`; legal range 1..4.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `pN_req`  in  1  port N (N=0,1) request; held, with its qualifiers stable, until `pN_gnt`.
- `pN_wr`  in  1  1 = write, 0 = read.
- `pN_lock`  in  1  request that ownership stay with port N after this grant.
- `pN_address`  in  DEPTH  access address.
- `pN_wr_data`  in  WIDTH  write data.
- `pN_gnt`  out  1  combinational; request accepted at this rising edge.
- `pN_rd_valid`  out  1  registered; `pN_rd_data` carries this port's read result this cycle.
- `pN_rd_data`  out  WIDTH  equals `mem_rd_data`; meaningful only with `pN_rd_valid`.
- `mem_enable`  out  1  registered memory enable.
- `mem_wr_enable`  out  1  registered memory write enable.
- `mem_address`  out  DEPTH  registered memory address.
- `mem_wr_data`  out  WIDTH  registered memory write data.
- `mem_rd_data`  in  WIDTH  memory read data.

## Operation

State:
- `last`: 1 bit, the port most recently granted.
- `lock_state`: UNLOCKED, LOCKED0 or LOCKED1.
- Read-tag shift pipe: READ_LATENCY+1 stages of {valid, port}.

Arbitration (combinational, each cycle):
- **UNLOCKED, one port requesting:** that port is granted.
- **UNLOCKED, both requesting:** the port != `last` is granted.
- **LOCKEDn:** only port n may be granted; the other port's request is held off (no grant), with no timeout.
- At most one `pN_gnt` is high per cycle. A grant is never issued without the matching `pN_req`.

Lock transitions (on a granted edge only):
- A grant to port n with `pn_lock`=1 enters LOCKEDn.
- A grant to port n with `pn_lock`=0 returns to UNLOCKED.
- Non-granted cycles leave `lock_state` unchanged.

Command issue:
- At a granted edge the memory outputs load the winner's fields: `mem_enable`=1, `mem_wr_enable`=`pN_wr`, address, write data. `last` updates to the winner.
- At a non-granted edge `mem_enable`=0 and `mem_wr_enable`=0; `mem_address`/`mem_wr_data` hold their previous values.

Read tracking:
- A granted read pushes {1, port} into the tag pipe.
- A granted write or idle cycle pushes {0, x}.
- `pN_rd_valid` = tail valid && tail port == N.
- Writes produce no response.

Reset (`resetn`=0, asynchronous, mid-operation included):
- All outputs go to 0: `pN_gnt` (reset forces it low), `pN_rd_valid`, `mem_*`.
- The tag pipe is cleared, so in-flight reads never return valid.
- `lock_state`=UNLOCKED; `last`=1, so port 0 wins the first contention.

## Timing

- **Grant:** the request is accepted in cycle C (`pN_gnt` high in C) and the memory command is driven during C+1.
- **Read latency:** `pN_rd_valid` is high for exactly one cycle, C+1+READ_LATENCY; with the default this is C+2.
- **Throughput:** one grant per cycle sustained; back-to-back reads return in issue order, one valid per cycle.
- **Read-after-write:** a write granted in C followed by a read of the same address granted in C+1 returns the new data. The memory performs the write at the end of C+1, before the read command is sampled at the end of C+2.
- **Request change after grant:** a request deasserted in the cycle after its grant starts no new access. A request held high after its grant is a new request.

## Test plan

- **Reset values:** hold `resetn`=0 for 10 cycles with both `pN_req`=1 -> every output 0, no grant; release -> `p0_gnt` in the first cycle.
- **Single read latency:** p0 reads fffc, with memory fffc=00 -> `p0_gnt` in C, `mem_enable`=1 with `mem_address`=fffc in C+1, `p0_rd_valid`=1 with `p0_rd_data`=00 in C+2 only; `p1_rd_valid` stays 0.
- **Contention:** both ports request continuously after reset -> grants alternate p0,p1,p0,p1 for 8 cycles; each `rd_valid` lands on the issuing port 2 cycles later.
- **Write then read:** p1 writes ff to 8000, then reads 8000 -> no valid for the write; read returns ff with `p1_rd_valid` at grant+2.
- **Lock:** p0 reads fffc with lock=1, then fffd with lock=0, while p1 requests throughout -> p1 gets no grant until after the fffd grant; p1 is granted in the next cycle.
- **Reset mid-flight:** assert `resetn` low in the cycle after a read grant -> no `rd_valid` ever appears for that read; lock state is cleared.
